// File: rtl/snake_input_sequencer_pkg.sv
// Shared types and constants for the snake input path: direction encoding,
// sequencer phases and the game-state codes reported by snake_controller.
package snake_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    localparam logic [1:0] GAME_STATE_ALIVE = 2'd0;
    localparam logic [1:0] GAME_STATE_DEAD  = 2'd1;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'b00,
        PH_ARMED   = 2'b01,
        PH_RUNNING = 2'b10,
        PH_DEAD    = 2'b11
    } phase_e;

    // Left/right and up/down differ only in the upper bit.
    function automatic logic [1:0] dir_opposite(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_input_sequencer_dir_queue.sv
// Small shift-register FIFO of pending turns; head is always entry 0 and the
// tail is the most recently pushed entry. Push and pop may share an edge.
module dir_queue #(
    parameter int DEPTH = 2
) (
    input  logic       clk_1,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [1:0] din,
    output logic [1:0] head,
    output logic [1:0] tail,
    output logic [2:0] level,
    output logic       full,
    output logic       empty
);

    logic [1:0] mem_q [DEPTH];
    logic [1:0] mem_d [DEPTH];
    logic [2:0] level_q;
    logic [2:0] level_d;

    always_comb begin
        mem_d   = mem_q;
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
            end
            // After a simultaneous pop the free slot has moved down by one.
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (3'(i) == level_q - {2'b00, pop}) mem_d[i] = din;
                end
            end
            if (push && !pop)      level_d = level_q + 3'd1;
            else if (pop && !push) level_d = level_q - 3'd1;
        end
    end

    always_comb begin
        tail = mem_q[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (3'(i + 1) == level_q) tail = mem_q[i];
        end
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            level_q <= level_d;
            mem_q   <= mem_d;
        end
    end

    assign head  = mem_q[0];
    assign level = level_q;
    assign full  = (level_q == 3'(DEPTH));
    assign empty = (level_q == 3'd0);

endmodule

// File: rtl/snake_input_sequencer.sv
// Turns button requests into a committed movement direction, one turn per game
// tick, and sequences the game phases from start countdown to death.
module snake_input_sequencer
    import snake_pkg::*;
#(
    parameter int COUNTDOWN_TICKS = 3,
    parameter int QUEUE_DEPTH     = 2
) (
    input  logic        clk_1,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        dir_req_valid,
    input  logic [1:0]  dir_req,
    input  logic [1:0]  game_state,
    output logic [1:0]  mov_dir,
    output logic        game_start,
    output logic        dir_req_ack,
    output logic        dir_req_dropped,
    output logic [1:0]  phase,
    output logic [2:0]  countdown,
    output logic [15:0] tick_count,
    output logic [2:0]  queue_level
);

    phase_e      phase_q, phase_d;
    logic [2:0]  countdown_q, countdown_d;
    logic [15:0] tick_count_q, tick_count_d;
    logic [1:0]  mov_dir_q, mov_dir_d;
    logic        ack_q, ack_d;
    logic        dropped_q, dropped_d;
    logic        start_prev_q;

    logic        start_edge, consume, commit_edge, dead_now;
    logic        q_push, q_pop, q_flush, q_full, q_empty, drop;
    logic [1:0]  q_head, q_tail, ref_dir;

    assign start_edge  = btn_start & ~start_prev_q;
    assign consume     = dir_req_valid & ~ack_q;
    assign dead_now    = (phase_q == PH_RUNNING) && (game_state == GAME_STATE_DEAD);
    assign commit_edge = (phase_q == PH_RUNNING) ||
                         ((phase_q == PH_ARMED) && (countdown_q <= 3'd1));
    assign q_pop       = commit_edge & ~q_empty & ~dead_now;
    assign q_flush     = dead_now || (phase_q == PH_DEAD);
    assign ref_dir     = q_empty ? mov_dir_q : q_tail;

    always_comb begin
        drop   = 1'b0;
        q_push = 1'b0;
        if (consume) begin
            if (phase_q == PH_IDLE || phase_q == PH_DEAD || dead_now)
                drop = 1'b1;
            else if (dir_req == ref_dir || dir_req == dir_opposite(ref_dir))
                drop = 1'b1;
            else if (q_full && !q_pop)
                drop = 1'b1;
            else
                q_push = 1'b1;
        end
    end

    always_comb begin
        phase_d      = phase_q;
        countdown_d  = countdown_q;
        tick_count_d = tick_count_q;
        mov_dir_d    = q_pop ? q_head : mov_dir_q;
        ack_d        = consume;
        dropped_d    = consume & drop;
        case (phase_q)
            PH_IDLE: begin
                if (start_edge) begin
                    if (COUNTDOWN_TICKS == 0) begin
                        phase_d = PH_RUNNING;
                    end else begin
                        phase_d     = PH_ARMED;
                        countdown_d = 3'(COUNTDOWN_TICKS);
                    end
                end
            end
            PH_ARMED: begin
                if (countdown_q <= 3'd1) begin
                    phase_d     = PH_RUNNING;
                    countdown_d = 3'd0;
                end else begin
                    countdown_d = countdown_q - 3'd1;
                end
            end
            PH_RUNNING: begin
                if (dead_now)
                    phase_d = PH_DEAD;
                else if (tick_count_q != 16'hFFFF)
                    tick_count_d = tick_count_q + 16'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            phase_q      <= PH_IDLE;
            countdown_q  <= '0;
            tick_count_q <= '0;
            mov_dir_q    <= DIR_RIGHT;
            ack_q        <= 1'b0;
            dropped_q    <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            phase_q      <= phase_d;
            countdown_q  <= countdown_d;
            tick_count_q <= tick_count_d;
            mov_dir_q    <= mov_dir_d;
            ack_q        <= ack_d;
            dropped_q    <= dropped_d;
            start_prev_q <= btn_start;
        end
    end

    dir_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk_1 (clk_1),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .flush (q_flush),
        .din   (dir_req),
        .head  (q_head),
        .tail  (q_tail),
        .level (queue_level),
        .full  (q_full),
        .empty (q_empty)
    );

    assign mov_dir         = mov_dir_q;
    assign game_start      = (phase_q == PH_RUNNING);
    assign dir_req_ack     = ack_q;
    assign dir_req_dropped = dropped_q;
    assign phase           = phase_q;
    assign countdown       = countdown_q;
    assign tick_count      = tick_count_q;

endmodule
